// File: rtl/cross_bar_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the
// request/ack crossbar and its per-slave arbiters.
package cross_bar_pkg;

    localparam int DEF_MASTER_N = 4;
    localparam int DEF_SLAVE_N  = 4;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;

    // Widest requester vector the pick helper handles (MASTER_N <= 16).
    localparam int RR_MAX_N = 16;
    localparam int RR_IDX_W = 4;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Bit replicated across DATA_W for the error responder's read data.
    localparam logic ERR_RDATA = 1'b1;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    typedef struct packed {
        logic                valid;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req_vec after ptr in cyclic order over n requesters
    // (0-based indices). Scanning from the far end lets the nearest win.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req_vec,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int                  n);
        rr_pick_t pick;
        int       idx;
        pick = '0;
        for (int i = RR_MAX_N; i >= 1; i--) begin
            if (i <= n) begin
                idx = int'(ptr) + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req_vec[idx]) begin
                    pick.valid = 1'b1;
                    pick.idx   = RR_IDX_W'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cross_bar_rr_arb.sv
// One target's arbiter: filters masters by decoded target, picks round-robin,
// and holds the grant until the target acks or the granted master drops req.
module cross_bar_rr_arb
    import cross_bar_pkg::*;
#(
    parameter  int MASTER_N = DEF_MASTER_N,
    parameter  int TGT_W    = 3,
    parameter  int ARB_ID   = 0,
    localparam int GNT_W    = $clog2(MASTER_N)
) (
    input  logic                            clk,
    input  logic                            aresetn,
    input  logic [MASTER_N-1:0]             master_req,
    input  logic [MASTER_N-1:0][TGT_W-1:0]  target,
    input  logic                            ack,
    output logic                            busy,
    output logic [GNT_W-1:0]                grant
);

    arb_state_t           state;
    logic [GNT_W-1:0]     rr_ptr;
    logic [RR_MAX_N-1:0]  cand;
    logic [RR_IDX_W-1:0]  ptr_ext;
    rr_pick_t             pick;
    logic [GNT_W-1:0]     pick_idx;

    // NOTE: every variable gets a default at the top of the block, so no
    // path through it can leave a value unassigned and infer a latch.
    always_comb begin
        cand    = '0;
        ptr_ext = '0;
        for (int m = 0; m < MASTER_N; m++) begin
            cand[m] = master_req[m] && (target[m] == TGT_W'(ARB_ID));
        end
        ptr_ext[GNT_W-1:0] = rr_ptr;
        pick               = rr_pick(cand, ptr_ext, MASTER_N);
        pick_idx           = GNT_W'(pick.idx);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= GNT_W'(MASTER_N - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick.valid) begin
                        grant <= pick_idx;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (ack) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= grant;
                    end else if (!master_req[grant]) begin
                        // Master abandoned the transfer: release, keep fairness pointer.
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign busy = (state == ARB_BUSY);

endmodule

// File: rtl/cross_bar_rr.sv
// Parametrised request/ack crossbar: address decode, per-slave round-robin
// arbitration with transaction-long grants, and an error responder.
module cross_bar_rr
    import cross_bar_pkg::*;
#(
    parameter  int MASTER_N = DEF_MASTER_N,
    parameter  int SLAVE_N  = DEF_SLAVE_N,
    parameter  int ADDR_W   = DEF_ADDR_W,
    parameter  int DATA_W   = DEF_DATA_W,
    localparam int SEL_W    = $clog2(SLAVE_N),
    localparam int TGT_W    = $clog2(SLAVE_N + 1),
    localparam int GNT_W    = $clog2(MASTER_N)
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic [MASTER_N:1]                master_req,
    input  logic [MASTER_N:1][ADDR_W-1:0]    master_addr,
    input  logic [MASTER_N:1]                master_cmd,
    input  logic [MASTER_N:1][DATA_W-1:0]    master_wdata,
    output logic [MASTER_N:1]                master_ack,
    output logic [MASTER_N:1][DATA_W-1:0]    master_rdata,
    output logic [MASTER_N:1]                master_err,
    output logic [SLAVE_N:1]                 slave_req,
    output logic [SLAVE_N:1][ADDR_W-1:0]     slave_addr,
    output logic [SLAVE_N:1]                 slave_cmd,
    output logic [SLAVE_N:1][DATA_W-1:0]     slave_wdata,
    input  logic [SLAVE_N:1]                 slave_ack,
    input  logic [SLAVE_N:1][DATA_W-1:0]     slave_rdata
);

    // Zero-based views of the ports; index SLAVE_N is the error responder.
    logic [MASTER_N-1:0]               req;
    logic [MASTER_N-1:0][ADDR_W-1:0]   addr;
    logic [MASTER_N-1:0]               cmd;
    logic [MASTER_N-1:0][DATA_W-1:0]   wdata;
    logic [MASTER_N-1:0][TGT_W-1:0]    target;

    logic [SLAVE_N:0]                  arb_busy;
    logic [SLAVE_N:0]                  arb_ack;
    logic [SLAVE_N:0][GNT_W-1:0]       arb_grant;
    logic [SLAVE_N:0][DATA_W-1:0]      arb_rdata;

    logic [SLAVE_N-1:0]                s_req;
    logic [SLAVE_N-1:0][ADDR_W-1:0]    s_addr;
    logic [SLAVE_N-1:0]                s_cmd;
    logic [SLAVE_N-1:0][DATA_W-1:0]    s_wdata;

    logic [MASTER_N-1:0]               m_ack;
    logic [MASTER_N-1:0][DATA_W-1:0]   m_rdata;
    logic [MASTER_N-1:0]               m_err;

    logic                              err_ack_q;
    logic                              err_ack;

    assign req   = master_req;
    assign addr  = master_addr;
    assign cmd   = master_cmd;
    assign wdata = master_wdata;

    always_comb begin
        target = '0;
        for (int m = 0; m < MASTER_N; m++) begin
            if (int'(addr[m][ADDR_W-1 -: SEL_W]) < SLAVE_N) begin
                target[m] = TGT_W'(addr[m][ADDR_W-1 -: SEL_W]);
            end else begin
                target[m] = TGT_W'(SLAVE_N);
            end
        end
    end

    for (genvar j = 0; j <= SLAVE_N; j++) begin : g_arb
        cross_bar_rr_arb #(
            .MASTER_N (MASTER_N),
            .TGT_W    (TGT_W),
            .ARB_ID   (j)
        ) u_arb (
            .clk        (clk),
            .aresetn    (aresetn),
            .master_req (req),
            .target     (target),
            .ack        (arb_ack[j]),
            .busy       (arb_busy[j]),
            .grant      (arb_grant[j])
        );
    end

    // Error responder answers on the second BUSY cycle, i.e. one cycle after grant.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            err_ack_q <= 1'b0;
        end else begin
            err_ack_q <= arb_busy[SLAVE_N] && !err_ack_q;
        end
    end

    assign err_ack   = err_ack_q && arb_busy[SLAVE_N];
    assign arb_ack   = {err_ack, slave_ack};
    assign arb_rdata = {{DATA_W{ERR_RDATA}}, slave_rdata};

    always_comb begin
        s_req   = '0;
        s_addr  = '0;
        s_cmd   = '0;
        s_wdata = '0;
        for (int s = 0; s < SLAVE_N; s++) begin
            if (arb_busy[s]) begin
                s_req[s]   = req[arb_grant[s]];
                s_addr[s]  = addr[arb_grant[s]];
                s_cmd[s]   = cmd[arb_grant[s]];
                s_wdata[s] = wdata[arb_grant[s]];
            end
        end
    end

    // A master holds at most one grant, so OR-ing the return paths never merges two acks.
    always_comb begin
        m_ack   = '0;
        m_rdata = '0;
        m_err   = '0;
        for (int j = 0; j <= SLAVE_N; j++) begin
            if (arb_busy[j] && arb_ack[j]) begin
                m_ack[arb_grant[j]]   = 1'b1;
                m_rdata[arb_grant[j]] = m_rdata[arb_grant[j]] | arb_rdata[j];
                if (j == SLAVE_N) begin
                    m_err[arb_grant[j]] = 1'b1;
                end
            end
        end
    end

    assign slave_req    = s_req;
    assign slave_addr   = s_addr;
    assign slave_cmd    = s_cmd;
    assign slave_wdata  = s_wdata;
    assign master_ack   = m_ack;
    assign master_rdata = m_rdata;
    assign master_err   = m_err;

endmodule

// File: tb/tb_cross_bar_rr.sv
// Directed bench for cross_bar_rr: a 4x4 instance for arbitration, return
// path and reset, and a 4x3 instance for the unmapped-address responder.
module tb_cross_bar_rr;
    import cross_bar_pkg::*;

    logic clk = 1'b0;
    logic aresetn;

    logic [4:1]        m_req;
    logic [4:1][31:0]  m_addr;
    logic [4:1]        m_cmd;
    logic [4:1][31:0]  m_wdata;
    logic [4:1]        m_ack;
    logic [4:1][31:0]  m_rdata;
    logic [4:1]        m_err;
    logic [4:1]        s_req;
    logic [4:1][31:0]  s_addr;
    logic [4:1]        s_cmd;
    logic [4:1][31:0]  s_wdata;
    logic [4:1]        s_ack;
    logic [4:1][31:0]  s_rdata;

    logic [4:1]        e_m_req;
    logic [4:1][31:0]  e_m_addr;
    logic [4:1]        e_m_cmd;
    logic [4:1][31:0]  e_m_wdata;
    logic [4:1]        e_m_ack;
    logic [4:1][31:0]  e_m_rdata;
    logic [4:1]        e_m_err;
    logic [3:1]        e_s_req;
    logic [3:1][31:0]  e_s_addr;
    logic [3:1]        e_s_cmd;
    logic [3:1][31:0]  e_s_wdata;
    logic [3:1]        e_s_ack;
    logic [3:1][31:0]  e_s_rdata;

    int n_applied    = 0;
    int n_miscompare = 0;

    always #5 clk = ~clk;

    cross_bar_rr #(.MASTER_N(4), .SLAVE_N(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .master_req   (m_req),
        .master_addr  (m_addr),
        .master_cmd   (m_cmd),
        .master_wdata (m_wdata),
        .master_ack   (m_ack),
        .master_rdata (m_rdata),
        .master_err   (m_err),
        .slave_req    (s_req),
        .slave_addr   (s_addr),
        .slave_cmd    (s_cmd),
        .slave_wdata  (s_wdata),
        .slave_ack    (s_ack),
        .slave_rdata  (s_rdata)
    );

    cross_bar_rr #(.MASTER_N(4), .SLAVE_N(3), .ADDR_W(32), .DATA_W(32)) dut3 (
        .clk          (clk),
        .aresetn      (aresetn),
        .master_req   (e_m_req),
        .master_addr  (e_m_addr),
        .master_cmd   (e_m_cmd),
        .master_wdata (e_m_wdata),
        .master_ack   (e_m_ack),
        .master_rdata (e_m_rdata),
        .master_err   (e_m_err),
        .slave_req    (e_s_req),
        .slave_addr   (e_s_addr),
        .slave_cmd    (e_s_cmd),
        .slave_wdata  (e_s_wdata),
        .slave_ack    (e_s_ack),
        .slave_rdata  (e_s_rdata)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle of slave-1 contention: inputs and the outputs expected mid-cycle.
    typedef struct {
        logic [4:1]  req;
        logic [4:1]  sack;
        logic [4:1]  exp_sreq;
        logic [4:1]  exp_mack;
        logic [31:0] exp_saddr1;
        logic [31:0] exp_swdata1;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        logic [4:1][31:0] exp_rd;

        // Grants on slave 1 rotate 1,2,3,4,1 two cycles apart; an ack while
        // idle is ignored; M2 dropping req mid-grant leaves the pointer alone.
        vecs[0]  = '{4'hF, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{4'hF, 4'h1, 4'h1, 4'h1, 32'h0000_0100, 32'hD000_0001};
        vecs[2]  = '{4'hF, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[3]  = '{4'hF, 4'h1, 4'h1, 4'h2, 32'h0000_0200, 32'hD000_0002};
        vecs[4]  = '{4'hF, 4'h1, 4'h0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[5]  = '{4'hF, 4'h1, 4'h1, 4'h4, 32'h0000_0300, 32'hD000_0003};
        vecs[6]  = '{4'hF, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[7]  = '{4'hF, 4'h1, 4'h1, 4'h8, 32'h0000_0400, 32'hD000_0004};
        vecs[8]  = '{4'hF, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[9]  = '{4'hF, 4'h1, 4'h1, 4'h1, 32'h0000_0100, 32'hD000_0001};
        vecs[10] = '{4'hF, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{4'hD, 4'h0, 4'h0, 4'h0, 32'h0000_0200, 32'hD000_0002};
        vecs[12] = '{4'hF, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[13] = '{4'hF, 4'h1, 4'h1, 4'h2, 32'h0000_0200, 32'hD000_0002};

        aresetn   = 1'b0;
        m_req     = '0;
        m_cmd     = {4{CMD_WRITE}};
        s_ack     = '0;
        s_rdata   = '0;
        s_rdata[1] = 32'h1111_0001;
        for (int m = 1; m <= 4; m++) begin
            m_addr[m]  = 32'h0000_0100 * m;
            m_wdata[m] = 32'hD000_0000 + m;
        end
        e_m_req   = '0;
        e_m_addr  = '0;
        e_m_cmd   = '0;
        e_m_wdata = '0;
        e_s_ack   = '0;
        e_s_rdata = '0;

        repeat (2) @(negedge clk);
        check("reset slave_req", s_req, 4'h0);
        check("reset master_ack", m_ack, 4'h0);
        check("reset slave_addr", s_addr, '0);
        check("reset err-dut slave_req", e_s_req, 3'h0);
        aresetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            m_req = vecs[i].req;
            s_ack = vecs[i].sack;
            #1;
            check($sformatf("v%0d slave_req", i), s_req, vecs[i].exp_sreq);
            check($sformatf("v%0d master_ack", i), m_ack, vecs[i].exp_mack);
            check($sformatf("v%0d slave_addr1", i), s_addr[1], vecs[i].exp_saddr1);
            check($sformatf("v%0d slave_wdata1", i), s_wdata[1], vecs[i].exp_swdata1);
            exp_rd = '0;
            for (int m = 1; m <= 4; m++) begin
                if (vecs[i].exp_mack[m]) exp_rd[m] = s_rdata[1];
            end
            check($sformatf("v%0d master_rdata", i), m_rdata, exp_rd);
        end
        @(negedge clk);
        m_req = '0;
        s_ack = '0;

        // Single read from slave 2, acked two cycles after slave_req rises.
        @(negedge clk);
        m_req      = 4'h1;
        m_addr[1]  = 32'h4000_0010;
        m_cmd[1]   = CMD_READ;
        s_rdata[2] = 32'hA5A5_0001;
        #1;
        check("read before grant slave_req", s_req, 4'h0);
        @(negedge clk); #1;
        check("read slave_req", s_req, 4'h2);
        check("read slave_addr2", s_addr[2], 32'h4000_0010);
        check("read slave_cmd", s_cmd, 4'h0);
        @(negedge clk); #1;
        check("read wait master_ack", m_ack, 4'h0);
        @(negedge clk);
        s_ack = 4'h2;
        #1;
        check("read master_ack", m_ack, 4'h1);
        check("read master_rdata1", m_rdata[1], 32'hA5A5_0001);
        check("read master_err", m_err, 4'h0);
        @(negedge clk);
        m_req = '0;
        s_ack = '0;
        #1;
        check("read done master_ack", m_ack, 4'h0);
        check("read done master_rdata", m_rdata, '0);

        // Concurrency: M1 -> slave 1, M2 -> slave 3, independent acks.
        @(negedge clk);
        m_req     = 4'h3;
        m_addr[1] = 32'h0000_0040;
        m_addr[2] = 32'h8000_0080;
        m_cmd     = {CMD_READ, CMD_READ, CMD_READ, CMD_WRITE};
        @(negedge clk); #1;
        check("conc slave_req", s_req, 4'h5);
        check("conc slave_cmd", s_cmd, 4'h1);
        check("conc slave_addr3", s_addr[3], 32'h8000_0080);
        @(negedge clk);
        s_ack = 4'h4;
        #1;
        check("conc ack3 master_ack", m_ack, 4'h2);
        check("conc ack3 slave_req", s_req, 4'h5);
        @(negedge clk);
        m_req = 4'h1;
        s_ack = 4'h1;
        #1;
        check("conc ack1 slave_req", s_req, 4'h1);
        check("conc ack1 master_ack", m_ack, 4'h1);
        @(negedge clk);
        m_req = '0;
        s_ack = '0;
        #1;
        check("conc done master_ack", m_ack, 4'h0);

        // Error responder on the 3-slave instance: select value 3 is unmapped.
        @(negedge clk);
        e_m_req     = 4'h4;
        e_m_addr[3] = 32'hC000_0000;
        #1;
        check("err t master_ack", e_m_ack, 4'h0);
        @(negedge clk); #1;
        check("err t+1 master_ack", e_m_ack, 4'h0);
        check("err t+1 master_err", e_m_err, 4'h0);
        check("err t+1 slave_req", e_s_req, 3'h0);
        @(negedge clk); #1;
        check("err t+2 master_ack", e_m_ack, 4'h4);
        check("err t+2 master_err", e_m_err, 4'h4);
        check("err t+2 master_rdata3", e_m_rdata[3], 32'hFFFF_FFFF);
        check("err t+2 master_rdata1", e_m_rdata[1], 32'h0);
        check("err t+2 slave_req", e_s_req, 3'h0);
        @(negedge clk);
        e_m_req = '0;
        #1;
        check("err done master_ack", e_m_ack, 4'h0);
        check("err done master_err", e_m_err, 4'h0);

        // Reset while slave 2 is busy with M2; afterwards M1 must win over M4.
        @(negedge clk);
        m_req     = 4'h2;
        m_addr[2] = 32'h4000_0000;
        @(negedge clk); #1;
        check("rst pre slave_req", s_req, 4'h2);
        #2;
        aresetn = 1'b0;
        s_ack   = 4'h2;
        #1;
        check("rst slave_req", s_req, 4'h0);
        check("rst slave_addr", s_addr, '0);
        check("rst master_ack", m_ack, 4'h0);
        check("rst master_rdata", m_rdata, '0);
        check("rst master_err", m_err, 4'h0);
        @(negedge clk);
        m_req = '0;
        s_ack = '0;
        @(negedge clk);
        aresetn   = 1'b1;
        m_req     = 4'h9;
        m_addr[1] = 32'h4000_0004;
        m_addr[4] = 32'h4000_0008;
        #1;
        check("post rst slave_req", s_req, 4'h0);
        @(negedge clk); #1;
        check("post rst slave_req granted", s_req, 4'h2);
        check("post rst winner addr", s_addr[2], 32'h4000_0004);
        @(negedge clk);
        s_ack = 4'h2;
        #1;
        check("post rst master_ack", m_ack, 4'h1);
        @(negedge clk);
        m_req = 4'h8;
        s_ack = '0;
        #1;
        check("post rst turnaround slave_req", s_req, 4'h0);
        @(negedge clk); #1;
        check("post rst next winner addr", s_addr[2], 32'h4000_0008);
        check("post rst next slave_req", s_req, 4'h2);
        @(negedge clk);
        m_req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
